// File: rtl/as512512512_uart_loader_pkg.sv
// Shared definitions for the UART command loader: command bytes, reply bytes
// and the loader's state encoding.
package as512512512_uart_loader_pkg;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] RPL_ACK = 8'h06;
    localparam logic [7:0] RPL_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_AH  = 3'd1,
        ST_GET_AL  = 3'd2,
        ST_GET_D   = 3'd3,
        ST_MEM_REQ = 3'd4,
        ST_REPLY   = 3'd5,
        ST_TX_ARM  = 3'd6,
        ST_TX_WAIT = 3'd7
    } state_t;

    // Commands that carry an address and go through the memory bus
    function automatic logic is_mem_cmd(input logic [7:0] b);
        return (b == CMD_W) || (b == CMD_R);
    endfunction

endpackage

// File: rtl/as512512512_uart_loader.sv
// Byte-level command engine between a UART and a memory-bus port: lets a
// serial host write/read memory and hold/release the core.
module as512512512_uart_loader
    import as512512512_uart_loader_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        uart_dout,
    input  logic              uart_has_byte,
    output logic              uart_clr_hb,
    output logic [7:0]        uart_din,
    output logic              uart_start,
    input  logic              uart_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_hold,
    output logic [2:0]        dbg_state
);

    // Handshakes: a byte is taken when has_byte=1 in an intake state and the
    // blanking window is closed; clr_hb pulses the cycle after. mem_req stays
    // high (addr/we/wdata stable) until the cycle mem_ack=1 is sampled.
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nx;
    logic [7:0]       cmd_q;
    logic [7:0]       reply_q;
    logic [15:0]      addr_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             blank_q;
    logic             arm_q;
    logic             in_get;
    logic             take;
    logic             tmo_hit;
    logic             fire;
    logic             cmd_is_w;

    assign cmd_is_w  = (cmd_q == CMD_W);
    assign mem_addr  = ADDR_W'(addr_q);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (take) state_nx = is_mem_cmd(uart_dout) ? ST_GET_AH : ST_REPLY;
            ST_GET_AH:  if (take) state_nx = ST_GET_AL;
                        else if (tmo_hit) state_nx = ST_IDLE;
            ST_GET_AL:  if (take) state_nx = cmd_is_w ? ST_GET_D : ST_MEM_REQ;
                        else if (tmo_hit) state_nx = ST_IDLE;
            ST_GET_D:   if (take) state_nx = ST_MEM_REQ;
                        else if (tmo_hit) state_nx = ST_IDLE;
            ST_MEM_REQ: if (mem_ack) state_nx = ST_REPLY;
            ST_REPLY:   if (fire) state_nx = ST_TX_ARM;
            ST_TX_ARM:  if (arm_q) state_nx = ST_TX_WAIT;
            ST_TX_WAIT: if (!uart_busy) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // has_byte is stale while clr_hb is out and for one cycle after it
    always_comb begin
        in_get  = (state == ST_GET_AH) || (state == ST_GET_AL) || (state == ST_GET_D);
        take    = ((state == ST_IDLE) || in_get) && uart_has_byte && !uart_clr_hb && !blank_q;
        tmo_hit = in_get && (tmo_cnt == TMO_W'(TIMEOUT));
        fire    = (state == ST_REPLY) && !uart_busy;
        mem_req = (state == ST_MEM_REQ);
        mem_we  = (state == ST_MEM_REQ) && cmd_is_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q       <= 8'h00;
            reply_q     <= 8'h00;
            addr_q      <= 16'h0000;
            mem_wdata   <= 8'h00;
            tmo_cnt     <= '0;
            blank_q     <= 1'b0;
            arm_q       <= 1'b0;
            uart_clr_hb <= 1'b0;
            uart_start  <= 1'b0;
            uart_din    <= 8'h00;
            cpu_hold    <= 1'b1;
        end else begin
            uart_clr_hb <= take;
            blank_q     <= uart_clr_hb;
            uart_start  <= fire;
            arm_q       <= (state == ST_TX_ARM);
            if (fire) uart_din <= reply_q;

            if (take || tmo_hit || !in_get) tmo_cnt <= '0;
            else                            tmo_cnt <= tmo_cnt + TMO_W'(1);

            case (state)
                ST_IDLE: if (take) begin
                    cmd_q   <= uart_dout;
                    reply_q <= (uart_dout == CMD_H || uart_dout == CMD_G) ? RPL_ACK : RPL_NAK;
                    if (uart_dout == CMD_H) cpu_hold <= 1'b1;
                    if (uart_dout == CMD_G) cpu_hold <= 1'b0;
                end
                ST_GET_AH:  if (take) addr_q[15:8] <= uart_dout;
                ST_GET_AL:  if (take) addr_q[7:0]  <= uart_dout;
                ST_GET_D:   if (take) mem_wdata    <= uart_dout;
                ST_MEM_REQ: if (mem_ack) reply_q   <= cmd_is_w ? RPL_ACK : mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_as512512512_uart_loader.sv
// Directed bench for the UART command loader, with behavioural UART and
// memory models acting on the falling edge.
module tb_as512512512_uart_loader;

    localparam int TIMEOUT = 100;
    localparam int ACK_DLY = 3;

    logic        clk;
    logic        rst_n;
    logic [7:0]  uart_dout;
    logic        uart_has_byte;
    logic        uart_clr_hb;
    logic [7:0]  uart_din;
    logic        uart_start;
    logic        uart_busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        cpu_hold;
    logic [2:0]  dbg_state;

    as512512512_uart_loader #(.ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .uart_dout(uart_dout), .uart_has_byte(uart_has_byte), .uart_clr_hb(uart_clr_hb),
        .uart_din(uart_din), .uart_start(uart_start), .uart_busy(uart_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [7:0]  exp_q[$];
    logic [7:0]  tx_got[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  rd_val;
    int          n_checks = 0;
    int          n_pass = 0;
    int          start_cnt = 0, start_busy_err = 0, overlap_err = 0;
    int          tx_pend = 0, busy_left = 0;
    int          txn_cnt = 0, req_cyc = 0, last_req_cyc = 0, stable_err = 0, drop_err = 0;
    logic [15:0] last_addr;
    logic        last_we;
    logic [7:0]  last_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART and memory models: values set here are sampled at the next rising edge
    always @(negedge clk) begin
        if (uart_clr_hb) uart_has_byte = 1'b0;
        else if (!uart_has_byte && rx_q.size() != 0) begin
            uart_dout     = rx_q.pop_front();
            uart_has_byte = 1'b1;
        end

        if (uart_start) begin
            if (uart_busy || tx_pend != 0) start_busy_err++;
            tx_got.push_back(uart_din);
            start_cnt++;
            tx_pend = 2;
        end else if (tx_pend != 0) begin
            tx_pend--;
            if (tx_pend == 0) begin
                uart_busy = 1'b1;
                busy_left = 8;
            end
        end else if (busy_left != 0) begin
            busy_left--;
            if (busy_left == 0) uart_busy = 1'b0;
        end

        if (mem_req && uart_start) overlap_err++;

        if (mem_ack) begin
            if (mem_req) drop_err++;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (req_cyc == 0) begin
                last_addr  = mem_addr;
                last_we    = mem_we;
                last_wdata = mem_wdata;
            end else if (mem_addr != last_addr || mem_we != last_we || mem_wdata != last_wdata) begin
                stable_err++;
            end
            req_cyc++;
            if (req_cyc == ACK_DLY + 1) begin
                mem_ack      = 1'b1;
                mem_rdata    = rd_val;
                txn_cnt++;
                last_req_cyc = req_cyc;
                req_cyc      = 0;
            end
        end
    end

    // driver tasks
    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int nbytes, input logic [7:0] exp_reply);
        logic [7:0] bs[4];
        bs = '{b0, b1, b2, b3};
        for (int i = 0; i < nbytes; i++) rx_q.push_back(bs[i]);
        exp_q.push_back(exp_reply);
    endtask

    task automatic expect_reply(input string tag);
        int n;
        n = 0;
        while (tx_got.size() == 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check_eq({tag, "_seen"}, 32'(tx_got.size() != 0), 1);
        if (tx_got.size() != 0 && exp_q.size() != 0)
            check_eq({tag, "_byte"}, 32'(tx_got.pop_front()), 32'(exp_q.pop_front()));
        n = 0;
        while ((dbg_state != 3'd0 || uart_busy) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check_eq({tag, "_idle"}, 32'(dbg_state), 0);
    endtask

    task automatic drain_rx(input string tag);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || uart_has_byte) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check_eq({tag, "_drained"}, 32'(rx_q.size() == 0 && !uart_has_byte), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        uart_dout = 8'h00;
        uart_has_byte = 1'b0;
        uart_busy = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        rd_val = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold", 32'(cpu_hold), 1);
        check_eq("rst_req", 32'(mem_req), 0);
        check_eq("rst_start", 32'(uart_start), 0);
        check_eq("rst_clr", 32'(uart_clr_hb), 0);
        check_eq("rst_addr", 32'(mem_addr), 0);
        check_eq("rst_state", 32'(dbg_state), 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("idle_state", 32'(dbg_state), 0);
        check_eq("idle_starts", start_cnt, 0);
        check_eq("idle_txn", txn_cnt, 0);

        send_cmd(8'h57, 8'h12, 8'h34, 8'hA5, 4, 8'h06);
        expect_reply("wr1");
        check_eq("wr1_txn", txn_cnt, 1);
        check_eq("wr1_addr", 32'(last_addr), 32'h1234);
        check_eq("wr1_we", 32'(last_we), 1);
        check_eq("wr1_data", 32'(last_wdata), 32'hA5);
        check_eq("wr1_req_cyc", last_req_cyc, 4);
        check_eq("wr1_starts", start_cnt, 1);

        rd_val = 8'h5A;
        send_cmd(8'h52, 8'h12, 8'h34, 8'h00, 3, 8'h5A);
        expect_reply("rd1");
        check_eq("rd1_txn", txn_cnt, 2);
        check_eq("rd1_addr", 32'(last_addr), 32'h1234);
        check_eq("rd1_we", 32'(last_we), 0);
        check_eq("rd1_starts", start_cnt, 2);

        send_cmd(8'h47, 8'h00, 8'h00, 8'h00, 1, 8'h06);
        expect_reply("go");
        check_eq("go_hold", 32'(cpu_hold), 0);
        send_cmd(8'h48, 8'h00, 8'h00, 8'h00, 1, 8'h06);
        expect_reply("halt");
        check_eq("halt_hold", 32'(cpu_hold), 1);
        check_eq("hg_txn", txn_cnt, 2);

        send_cmd(8'h7F, 8'h00, 8'h00, 8'h00, 1, 8'h15);
        expect_reply("nak");
        check_eq("nak_txn", txn_cnt, 2);
        send_cmd(8'h57, 8'h00, 8'h01, 8'hFF, 4, 8'h06);
        expect_reply("wr2");
        check_eq("wr2_txn", txn_cnt, 3);
        check_eq("wr2_addr", 32'(last_addr), 32'h0001);
        check_eq("wr2_data", 32'(last_wdata), 32'hFF);
        check_eq("wr2_we", 32'(last_we), 1);

        rx_q.push_back(8'h57);
        rx_q.push_back(8'h12);
        drain_rx("tmo");
        repeat (TIMEOUT + 5) @(posedge clk);
        @(negedge clk);
        check_eq("tmo_state", 32'(dbg_state), 0);
        check_eq("tmo_starts", start_cnt, 6);
        check_eq("tmo_txn", txn_cnt, 3);
        rd_val = 8'h3C;
        send_cmd(8'h52, 8'h00, 8'h00, 8'h00, 3, 8'h3C);
        expect_reply("rd2");
        check_eq("rd2_txn", txn_cnt, 4);
        check_eq("rd2_addr", 32'(last_addr), 32'h0000);
        check_eq("rd2_we", 32'(last_we), 0);

        send_cmd(8'h47, 8'h00, 8'h00, 8'h00, 1, 8'h06);
        expect_reply("go2");
        check_eq("go2_hold", 32'(cpu_hold), 0);
        rx_q.push_back(8'h57);
        rx_q.push_back(8'hAB);
        drain_rx("mid");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_state", 32'(dbg_state), 0);
        check_eq("mid_rst_hold", 32'(cpu_hold), 1);
        check_eq("mid_rst_req", 32'(mem_req), 0);
        rst_n = 1'b1;
        rd_val = 8'h77;
        send_cmd(8'h52, 8'h12, 8'h34, 8'h00, 3, 8'h77);
        expect_reply("rd3");
        check_eq("rd3_txn", txn_cnt, 5);
        check_eq("rd3_addr", 32'(last_addr), 32'h1234);

        repeat (20) @(posedge clk);
        check_eq("total_starts", start_cnt, 9);
        check_eq("extra_replies", 32'(tx_got.size()), 0);
        check_eq("req_stable", stable_err, 0);
        check_eq("req_drop", drop_err, 0);
        check_eq("req_start_overlap", overlap_err, 0);
        check_eq("start_while_busy", start_busy_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
